// File: rtl/imem_line_buffer_if.sv
// Fetch-side and wide-memory-side signals of the instruction line buffer.
// cpu_valid/cpu_ready: one-cycle ready pulse per request; imem_valid is held until the one-cycle imem_ready pulse.
interface imem_line_buffer_if #(
   parameter int NUM_BLOCKS = 4
);
   logic                       cpu_valid;
   logic                       cpu_ready;
   logic [31:0]                cpu_addr;
   logic [31:0]                cpu_rdata;
   logic                       flush;
   logic                       imem_valid;
   logic                       imem_ready;
   logic [31:0]                imem_addr;
   logic [32*NUM_BLOCKS-1:0]   imem_rdata;

   modport slave (
      input  cpu_valid, cpu_addr, flush, imem_ready, imem_rdata,
      output cpu_ready, cpu_rdata, imem_valid, imem_addr
   );

   modport master (
      output cpu_valid, cpu_addr, flush, imem_ready, imem_rdata,
      input  cpu_ready, cpu_rdata, imem_valid, imem_addr
   );
endinterface

// File: rtl/imem_line_buffer.sv
// Single-line instruction fetch buffer: serves hits from the held line in one cycle,
// refills the line from the wide memory on a miss, and counts hits and misses.
module imem_line_buffer #(
   parameter int NUM_BLOCKS = 4
) (
   input  logic                clk,
   input  logic                reset,
   imem_line_buffer_if.slave   bus,
   output logic [31:0]         hit_count,
   output logic [31:0]         miss_count,
   output logic                dbg_state
);
   localparam int OFS = $clog2(NUM_BLOCKS);
   localparam int IW  = (OFS > 0) ? OFS : 1;
   localparam int TW  = 30 - OFS;
   localparam int LW  = 32 * NUM_BLOCKS;

   typedef enum logic {IDLE, FILL} state_t;

   state_t           state, state_next;
   logic             line_valid;
   logic             fill_flushed;
   logic [TW-1:0]    line_tag;
   logic [LW-1:0]    line_data;
   logic [IW-1:0]    fill_idx;
   logic [TW-1:0]    req_tag;
   logic [IW-1:0]    req_idx;
   logic             accept, hit, miss, fill_done;
   logic             unused_addr_bits;

   assign req_tag          = bus.cpu_addr[31:2+OFS];
   assign unused_addr_bits = ^bus.cpu_addr[1:0];
   assign dbg_state        = (state == FILL);

   generate
      if (OFS > 0) begin : g_idx
         assign req_idx = bus.cpu_addr[2+IW-1:2];
      end else begin : g_no_idx
         assign req_idx = '0;
      end
   endgenerate

   function automatic logic [31:0] word_sel(input logic [LW-1:0] line, input logic [IW-1:0] idx);
      word_sel = line[31:0];
      for (int k = 0; k < NUM_BLOCKS; k++)
         if (idx == IW'(k)) word_sel = line[32*k +: 32];
   endfunction

   // flush is folded into the hit test so a flush arriving with a request forces a refill
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      hit        = 1'b0;
      miss       = 1'b0;
      fill_done  = 1'b0;
      case (state)
         IDLE: begin
            accept = bus.cpu_valid && !bus.cpu_ready;
            hit    = accept && line_valid && !bus.flush && (line_tag == req_tag);
            miss   = accept && !hit;
            if (miss) state_next = FILL;
         end
         FILL: begin
            fill_done = bus.imem_ready;
            if (fill_done) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         line_valid     <= 1'b0;
         fill_flushed   <= 1'b0;
         fill_idx       <= '0;
         bus.cpu_ready  <= 1'b0;
         bus.cpu_rdata  <= '0;
         bus.imem_valid <= 1'b0;
         bus.imem_addr  <= '0;
         hit_count      <= '0;
         miss_count     <= '0;
      end else begin
         state         <= state_next;
         bus.cpu_ready <= 1'b0;
         if (bus.flush) line_valid <= 1'b0;
         if (hit) begin
            bus.cpu_ready <= 1'b1;
            bus.cpu_rdata <= word_sel(line_data, req_idx);
            hit_count     <= hit_count + 32'd1;
         end
         if (miss) begin
            bus.imem_valid <= 1'b1;
            bus.imem_addr  <= {req_tag, {(2+OFS){1'b0}}};
            fill_idx       <= req_idx;
            fill_flushed   <= 1'b0;
            miss_count     <= miss_count + 32'd1;
         end
         if (state == FILL && bus.flush) fill_flushed <= 1'b1;
         // a flush seen at any point of the fill leaves the new line invalid
         if (fill_done) begin
            line_data      <= bus.imem_rdata;
            line_tag       <= bus.imem_addr[31:2+OFS];
            line_valid     <= !(bus.flush || fill_flushed);
            bus.cpu_rdata  <= word_sel(bus.imem_rdata, fill_idx);
            bus.cpu_ready  <= 1'b1;
            bus.imem_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_imem_line_buffer.sv
// Randomized scoreboard bench for imem_line_buffer (4-word lines) plus a directed 1-word-line build.
module tb_imem_line_buffer;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   imem_line_buffer_if #(.NUM_BLOCKS(4)) bus ();
   imem_line_buffer_if #(.NUM_BLOCKS(1)) bus1 ();
   logic [31:0] hit_count, miss_count, hc1, mc1;
   logic        dbg_state, dbg1;

   imem_line_buffer #(.NUM_BLOCKS(4)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .hit_count(hit_count), .miss_count(miss_count), .dbg_state(dbg_state));
   imem_line_buffer #(.NUM_BLOCKS(1)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1),
      .hit_count(hc1), .miss_count(mc1), .dbg_state(dbg1));

   int n_tests = 0;
   int n_fail  = 0;
   logic [95:0] exp_q[$];

   // reference state: which line is buffered and how many hits/misses so far
   bit          m_valid = 0;
   logic [31:0] m_line  = '0;
   logic [31:0] m_hits  = '0;
   logic [31:0] m_miss  = '0;
   bit          held_prev = 0;
   int          mem_lat = 1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hA000_0000 + (a >> 2);
   endfunction

   function automatic logic [127:0] line4(input logic [31:0] la);
      logic [127:0] l;
      for (int k = 0; k < 4; k++) l[32*k +: 32] = mem_word(la + 32'(4*k));
      return l;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk); #2;
   endtask

   // wide memory for the 4-word build: ready after mem_lat cycles, ignores valid while ready
   initial begin
      logic [31:0] req_addr;
      bit pend;
      int cnt;
      pend = 0; cnt = 0; req_addr = '0;
      bus.imem_ready = 1'b0;
      bus.imem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (bus.imem_ready) bus.imem_ready = 1'b0;
         else if (pend) begin
            cnt--;
            if (cnt == 0) begin
               bus.imem_ready = 1'b1;
               bus.imem_rdata = line4(req_addr);
               pend = 0;
            end
         end else if (bus.imem_valid && !reset) begin
            pend = 1; cnt = mem_lat; req_addr = bus.imem_addr;
         end
      end
   end

   // one-cycle wide memory for the 1-word build
   initial begin
      bit pend1;
      pend1 = 0;
      bus1.imem_ready = 1'b0;
      bus1.imem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (bus1.imem_ready) bus1.imem_ready = 1'b0;
         else if (pend1) begin
            bus1.imem_ready = 1'b1;
            bus1.imem_rdata = mem_word(bus1.imem_addr);
            pend1 = 0;
         end else if (bus1.imem_valid && !reset) pend1 = 1;
      end
   end

   // scoreboard monitor
   initial begin
      logic [95:0] e;
      forever begin
         @(negedge clk);
         if (!reset && bus.cpu_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_cpu_ready", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("cpu_rdata", bus.cpu_rdata, e[95:64]);
               check("hit_count", hit_count, e[63:32]);
               check("miss_count", miss_count, e[31:0]);
            end
         end
      end
   end

   // fmode: 0 none, 1 flush in first FILL cycle, 2 flush together with imem_ready
   task automatic do_req(input logic [31:0] addr, input bit fl_acc_in, input int fmode, input bit hold);
      bit exp_hit, fl_acc, done, prev_mr;
      int acc, cyc;
      logic [31:0] la;
      fl_acc  = fl_acc_in && !held_prev;
      acc     = held_prev ? 2 : 1;
      la      = addr & ~32'hF;
      exp_hit = m_valid && (m_line == la) && !fl_acc;
      if (exp_hit) m_hits++;
      else begin
         m_miss++;
         m_line  = la;
         m_valid = (fmode == 0);
      end
      exp_q.push_back({mem_word(addr & ~32'h3), m_hits, m_miss});
      bus.cpu_addr  = addr;
      bus.cpu_valid = 1'b1;
      bus.flush     = fl_acc;
      cyc = 0; done = 0; prev_mr = 0;
      while (!done && cyc < 40) begin
         tick();
         cyc++;
         if (cyc >= acc) bus.flush = 1'b0;
         if (cyc == acc && !exp_hit) begin
            check("miss_imem_valid", {31'd0, bus.imem_valid}, 32'd1);
            check("miss_imem_addr", bus.imem_addr, la);
         end
         if (bus.cpu_ready) begin
            done = 1;
            if (exp_hit) begin
               check("hit_latency", cyc, acc);
               check("hit_no_imem_valid", {31'd0, bus.imem_valid}, 32'd0);
            end else begin
               check("ready_after_imem_ready", {31'd0, prev_mr}, 32'd1);
               if (mem_lat == 1) check("miss_latency", cyc, acc + 2);
            end
         end else begin
            if (fmode == 1 && cyc == acc) bus.flush = 1'b1;
            if (fmode == 2 && bus.imem_ready) bus.flush = 1'b1;
         end
         prev_mr = bus.imem_ready;
      end
      if (!done) check("req_timeout", 32'd1, 32'd0);
      bus.flush = 1'b0;
      held_prev = hold;
      if (!hold) begin
         bus.cpu_valid = 1'b0;
         tick();
      end
   endtask

   task automatic idle_flush();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      m_valid = 0;
   endtask

   initial begin
      logic [31:0] a, seen_addr;
      int rdy_cnt, cyc;
      bit got;
      reset = 1'b1;
      bus.cpu_valid = 1'b0; bus.cpu_addr = '0; bus.flush = 1'b0;
      bus1.cpu_valid = 1'b0; bus1.cpu_addr = '0; bus1.flush = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      check("rst_cpu_ready", {31'd0, bus.cpu_ready}, 32'd0);
      check("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
      check("rst_imem_valid", {31'd0, bus.imem_valid}, 32'd0);
      check("rst_imem_addr", bus.imem_addr, 32'd0);
      check("rst_hit_count", hit_count, 32'd0);
      check("rst_miss_count", miss_count, 32'd0);
      check("rst_dbg_state", {31'd0, dbg_state}, 32'd0);
      tick();

      mem_lat = 1;
      do_req(32'h8, 0, 0, 0);
      do_req(32'h0, 0, 0, 0);
      do_req(32'h4, 0, 0, 0);
      do_req(32'hC, 0, 0, 0);
      do_req(32'h10, 0, 0, 0);
      do_req(32'h0, 0, 0, 0);
      do_req(32'h20, 0, 2, 0);
      do_req(32'h24, 0, 0, 0);
      do_req(32'h28, 1, 0, 0);
      do_req(32'h20, 0, 0, 1);
      do_req(32'h2C, 0, 0, 1);
      do_req(32'h24, 0, 0, 0);
      do_req(32'h30, 0, 1, 0);
      do_req(32'h34, 0, 0, 0);

      for (int i = 0; i < 300; i++) begin
         mem_lat = $urandom_range(1, 3);
         a = {($urandom_range(0, 3) == 0) ? 24'hFFFF_FF : 24'h0, 8'h0}
             | (32'($urandom_range(0, 5)) << 4) | (32'($urandom_range(0, 3)) << 2);
         if (!held_prev && $urandom_range(0, 19) == 0) idle_flush();
         do_req(a, $urandom_range(0, 9) == 0,
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0,
                (i != 299) && ($urandom_range(0, 3) == 0));
      end
      repeat (3) tick();
      check("queue_drained", exp_q.size(), 32'd0);

      // reset in the cycle after imem_valid rises
      mem_lat = 1;
      idle_flush();
      bus.cpu_addr  = 32'h40;
      bus.cpu_valid = 1'b1;
      tick();
      check("rstfill_imem_valid_up", {31'd0, bus.imem_valid}, 32'd1);
      reset = 1'b1;
      bus.cpu_valid = 1'b0;
      tick();
      reset = 1'b0;
      m_valid = 0; m_hits = '0; m_miss = '0;
      check("rstfill_imem_valid", {31'd0, bus.imem_valid}, 32'd0);
      check("rstfill_hit_count", hit_count, 32'd0);
      check("rstfill_miss_count", miss_count, 32'd0);
      rdy_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.cpu_ready) rdy_cnt++;
         tick();
      end
      check("rstfill_no_cpu_ready", rdy_cnt, 32'd0);
      do_req(32'h44, 0, 0, 0);
      check("rstfill_refetch_misses", miss_count, 32'd1);

      // 1-word-line build
      bus1.cpu_addr  = 32'h4;
      bus1.cpu_valid = 1'b1;
      got = 0; cyc = 0; seen_addr = 32'hFFFF_FFFF;
      while (!got && cyc < 20) begin
         tick();
         cyc++;
         if (bus1.imem_valid) seen_addr = bus1.imem_addr;
         if (bus1.cpu_ready) got = 1;
      end
      check("nb1_miss_ready", {31'd0, got}, 32'd1);
      check("nb1_miss_latency", cyc, 32'd3);
      check("nb1_imem_addr", seen_addr, 32'h4);
      check("nb1_miss_rdata", bus1.cpu_rdata, mem_word(32'h4));
      check("nb1_miss_count", mc1, 32'd1);
      bus1.cpu_valid = 1'b0;
      tick();
      bus1.cpu_valid = 1'b1;
      tick();
      check("nb1_hit_ready", {31'd0, bus1.cpu_ready}, 32'd1);
      check("nb1_hit_rdata", bus1.cpu_rdata, mem_word(32'h4));
      check("nb1_hit_count", hc1, 32'd1);
      check("nb1_hit_no_imem_valid", {31'd0, bus1.imem_valid}, 32'd0);
      bus1.cpu_valid = 1'b0;
      repeat (2) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/imem_line_buffer.md
# imem_line_buffer

- Single-line fetch buffer and sequencer between the core's 32-bit instruction fetch port and the wide instruction memory (`32*NUM_BLOCKS`-bit lines).
- Holds the most recently fetched line and serves hits from it in one cycle.
- On a miss, it issues one wide-memory request, fills the line and returns the requested word.
- Keeps hit/miss counters used to evaluate fetch bandwidth for the code-compression experiments.

## Interface
Parameters:
- `NUM_BLOCKS`, default 4: 32-bit words per line. Must be a power of two, ≥1. Must match the wide memory's `NUM_BLOCKS`.

Ports:
- `clk` in 1: sole clock; all logic on posedge.
- `reset` in 1: synchronous, active-high reset.
- `cpu_valid` in 1: fetch request from core.
- `cpu_ready` out 1: one-cycle pulse; `cpu_rdata` valid while high.
- `cpu_addr` in 32: byte address of instruction word; bits [1:0] ignored.
- `cpu_rdata` out 32: returned instruction word.
- `flush` in 1: invalidate buffered line (e.g. after imem reload).
- `imem_valid` out 1: request to wide memory.
- `imem_ready` in 1: wide memory response pulse.
- `imem_addr` out 32: line-aligned byte address (low `2+log2(NUM_BLOCKS)` bits zero).
- `imem_rdata` in `32*NUM_BLOCKS`: returned line; word k at bits [32k+31:32k].
- `hit_count` out 32: number of requests served from the buffer.
- `miss_count` out 32: number of requests that required a fill.

## Operation
- `OFS = log2(NUM_BLOCKS)`.
  - Tag = `cpu_addr[31:2+OFS]`.
  - Word index = `cpu_addr[2+OFS-1:2]`.
  - Index is fixed 0 when `NUM_BLOCKS==1`; the `OFS=0` case must elaborate cleanly.
- State: `line_valid`, `line_tag`, `line_data[32*NUM_BLOCKS-1:0]`, FSM {IDLE, FILL}.
- IDLE:
  - A request is accepted when `cpu_valid && !cpu_ready`.
  - Hit (`line_valid` && tag match):
    - `cpu_ready<=1`.
    - `cpu_rdata<=line_data` word[index].
    - `hit_count++`.
    - Stay in IDLE.
  - Miss:
    - `imem_valid<=1`.
    - `imem_addr<={cpu_addr[31:2+OFS], (2+OFS)'b0}`.
    - Latch the word index.
    - `miss_count++`.
    - Go to FILL.
- FILL:
  - Hold `imem_valid`/`imem_addr` until `imem_ready`.
  - On `imem_ready`:
    - `line_data<=imem_rdata`, `line_tag<=`latched tag, `line_valid<=1`.
    - `cpu_rdata<=imem_rdata` word[latched index], `cpu_ready<=1`.
    - `imem_valid<=0`.
    - Go to IDLE.
  - `cpu_valid`/`cpu_addr` are not re-examined in FILL.
- `cpu_ready` and `imem_valid` are never high in the same cycle as a new acceptance; `cpu_ready` is high for exactly one cycle per accepted request.
- Core rule: `cpu_addr` stable while `cpu_valid` high until `cpu_ready`. If `cpu_valid` stays high after `cpu_ready`, the next cycle is a new request.
- Flush:
  - Clears `line_valid` at the clock edge. `flush` is sampled before the IDLE hit test in the same cycle (flush + request ⇒ miss).
  - Flush in FILL: the in-flight fill still completes and serves the core, but `line_valid` ends 0 (flush wins if simultaneous with `imem_ready`, or if asserted any cycle during FILL).
- Counters: 32-bit, wrap modulo 2^32, increment once per accepted request, cleared only by reset.

## Timing
- Reset values:
  - `cpu_ready=0`, `cpu_rdata=0`, `imem_valid=0`, `imem_addr=0`, `hit_count=0`, `miss_count=0`.
  - `line_valid=0`, FSM=IDLE.
  - `line_data`/`line_tag` need no reset.
- Request first high in cycle n, all outputs registered:
  - Hit: `cpu_ready` high in cycle n+1.
  - Miss:
    - `imem_valid` high from cycle n+1.
    - With the one-cycle wide memory, `imem_ready` is high in n+2 and `cpu_ready` in n+3.
    - In general `cpu_ready` is one cycle after `imem_ready`.
- `imem_valid` remains high in the `imem_ready` cycle and drops the cycle after. The memory ignores valid while its ready is high, so no duplicate read occurs.
- Back-to-back hits with `cpu_valid` held high: one word every 2 cycles (accept, ready, accept...).
- Reset mid-FILL: FSM to IDLE, `imem_valid=0` the next cycle, and no `cpu_ready` is produced. A stale `imem_ready` arriving in IDLE is ignored and does not write the line.
- `imem_ready` in IDLE without an outstanding request: ignored.

## Test plan
- **Cold miss** (`NUM_BLOCKS=4`): reset, then request 0x0000_0008 against a memory with word k = 0xA000_0000+k.
  - `imem_addr`=0x0000_0000, `cpu_ready` in cycle n+3, `cpu_rdata`=0xA000_0002, `miss_count`=1.
- **Same-line hits**: follow with 0x0, 0x4, 0xC.
  - Each is ready in n+1 with 0xA000_0000/1/3.
  - No `imem_valid`; `hit_count`=3.
- **Line change**: request 0x0000_0010, then 0x0000_0000.
  - Two misses, `imem_addr` 0x10 then 0x0; `miss_count`+2.
- **Flush**:
  - Flush concurrent with `imem_ready` during a fill of 0x20: the core still receives its word, and a following request to 0x24 misses.
  - Flush with a hit-eligible request in IDLE: the request is treated as a miss.
- **Reset mid-FILL**: assert `reset` in the cycle after `imem_valid` rises.
  - No `cpu_ready`; `imem_valid`=0; counters=0.
  - The next request to the same line misses.
- **`NUM_BLOCKS=1` build**: request 0x4 then 0x4 again.
  - First request misses with `imem_addr`=0x4; second hits with the same word.
